// File: rtl/led_pwm_chaser.sv
// ----------------------------------------------------------------------------
// led_pwm_chaser
//   Moving single-position LED chaser with global PWM brightness. Supports
//   rotate up, rotate down, bounce and hold step modes at a programmable step
//   rate. An optional fading trail lights the two previous distinct positions
//   at half and quarter duty. It is compiled in when the macro
//   LED_PWM_CHASER_TRAIL_EN is defined.
//
// Parameters
//   N_LED    : number of LEDs (>= 3)
//   PWM_BITS : PWM counter / duty width
//   STEP_DIV : clock cycles per position step (>= 1)
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   en         : step enable; the step prescaler holds while low
//   mode       : 00 rotate up, 01 rotate down, 10 bounce, 11 hold
//   duty       : global brightness, compared unsigned against pwm counter
//   led        : registered LED drive
//   step_pulse : registered one-cycle strobe, high while a new position is
//                first visible
// ----------------------------------------------------------------------------
module led_pwm_chaser #(
    parameter int N_LED    = 10,
    parameter int PWM_BITS = 7,
    parameter int STEP_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [N_LED-1:0]    led,
    output logic                step_pulse
);

    localparam int POS_W = $clog2(N_LED);
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [POS_W-1:0]    POS_ZERO  = POS_W'(0);
    localparam logic [POS_W-1:0]    POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]    POS_MAX   = POS_W'(N_LED - 1);
    localparam logic [POS_W-1:0]    POS_MAXM1 = POS_W'(N_LED - 2);
    localparam logic [DIV_W-1:0]    DIV_ZERO  = DIV_W'(0);
    localparam logic [DIV_W-1:0]    DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0]    DIV_MAX   = DIV_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic [POS_W-1:0]    pos_r;
    logic                dir_r;
    logic [POS_W-1:0]    pos_nxt_s;
    logic                dir_nxt_s;
    logic                step_s;
    logic                main_on_s;
    logic [N_LED-1:0]    led_nxt_s;
    logic [N_LED-1:0]    led_r;
    logic                step_pulse_r;

`ifdef LED_PWM_CHASER_TRAIL_EN
    logic [POS_W-1:0]    h1_r;
    logic [POS_W-1:0]    h2_r;
    logic                h1_on_s;
    logic                h2_on_s;
`endif

    // A step happens on the last prescaler count of an enabled cycle; mode is
    // only consulted here, so mode changes between steps are naturally ignored.
    assign step_s = en && (div_cnt_r == DIV_MAX);

    // Free-running PWM counter and enable-gated step prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
            div_cnt_r <= DIV_ZERO;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
            if (step_s) begin
                div_cnt_r <= DIV_ZERO;
            end else if (en) begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end else begin
                div_cnt_r <= div_cnt_r;
            end
        end
    end

    // Next position/direction for each step mode.
    always_comb begin
        pos_nxt_s = pos_r;
        dir_nxt_s = dir_r;
        case (mode)
            MODE_UP: begin
                pos_nxt_s = (pos_r == POS_MAX) ? POS_ZERO : (pos_r + POS_ONE);
                dir_nxt_s = 1'b0;
            end
            MODE_DOWN: begin
                pos_nxt_s = (pos_r == POS_ZERO) ? POS_MAX : (pos_r - POS_ONE);
                dir_nxt_s = 1'b0;
            end
            MODE_BOUNCE: begin
                // Turnarounds skip straight to the neighbour so no position repeats.
                if (!dir_r) begin
                    if (pos_r == POS_MAX) begin
                        pos_nxt_s = POS_MAXM1;
                        dir_nxt_s = 1'b1;
                    end else begin
                        pos_nxt_s = pos_r + POS_ONE;
                    end
                end else begin
                    if (pos_r == POS_ZERO) begin
                        pos_nxt_s = POS_ONE;
                        dir_nxt_s = 1'b0;
                    end else begin
                        pos_nxt_s = pos_r - POS_ONE;
                    end
                end
            end
            MODE_HOLD: begin
                pos_nxt_s = pos_r;
                dir_nxt_s = dir_r;
            end
            default: begin
                pos_nxt_s = pos_r;
                dir_nxt_s = dir_r;
            end
        endcase
    end

    // Position/direction registers advance only on step cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r <= POS_ZERO;
            dir_r <= 1'b0;
        end else if (step_s) begin
            pos_r <= pos_nxt_s;
            dir_r <= dir_nxt_s;
        end else begin
            pos_r <= pos_r;
            dir_r <= dir_r;
        end
    end

`ifdef LED_PWM_CHASER_TRAIL_EN
    // Trail history only shifts when the lit position actually moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_r <= POS_ZERO;
            h2_r <= POS_ZERO;
        end else if (step_s && (pos_nxt_s != pos_r)) begin
            h2_r <= h1_r;
            h1_r <= pos_r;
        end else begin
            h1_r <= h1_r;
            h2_r <= h2_r;
        end
    end

    assign h1_on_s = pwm_cnt_r < {1'b0, duty[PWM_BITS-1:1]};
    assign h2_on_s = pwm_cnt_r < {2'b00, duty[PWM_BITS-1:2]};
`endif

    assign main_on_s = pwm_cnt_r < duty;

    // LED pattern for this cycle; pos wins over h1, which wins over h2.
    always_comb begin
        led_nxt_s = {N_LED{1'b0}};
        for (int i = 0; i < N_LED; i++) begin
            if (pos_r == POS_W'(i)) begin
                led_nxt_s[i] = main_on_s;
`ifdef LED_PWM_CHASER_TRAIL_EN
            end else if (h1_r == POS_W'(i)) begin
                led_nxt_s[i] = h1_on_s;
            end else if (h2_r == POS_W'(i)) begin
                led_nxt_s[i] = h2_on_s;
`endif
            end else begin
                led_nxt_s[i] = 1'b0;
            end
        end
    end

    // Output registers: led lags pos by one cycle, step_pulse aligns with new pos.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r        <= {N_LED{1'b0}};
            step_pulse_r <= 1'b0;
        end else begin
            led_r        <= led_nxt_s;
            step_pulse_r <= step_s;
        end
    end

    assign led        = led_r;
    assign step_pulse = step_pulse_r;

endmodule

// File: doc/led_pwm_chaser.md
# led_pwm_chaser

Parametrised LED chaser driving `N_LED` outputs with a single moving lit position. The block supports rotate-left, rotate-right, bounce and hold modes, a programmable step rate and global PWM brightness. An optional fading trail lights the two previous positions at reduced brightness. It sits between the board-level control registers and the LED pins, and is the multi-mode successor to the fixed one-hot rotating LED driver.

## Interface
- `N_LED`, 10, number of LEDs; must be ≥3.
- `PWM_BITS`, 7, PWM counter and duty width.
- `STEP_DIV`, 50000, clock cycles per position step; must be ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  step enable; the prescaler holds while low.
- `mode`  in  2  step mode: 00 rotate up, 01 rotate down, 10 bounce, 11 hold.
- `duty`  in  PWM_BITS  global brightness.
- `led`  out  N_LED  LED drive, registered.
- `step_pulse`  out  1  one-cycle strobe on each position step, registered.

## Operation
- `pwm_cnt` (PWM_BITS wide) is free-running and wraps from 2^PWM_BITS−1 to 0. It runs regardless of `en`.
- `div_cnt` counts 0..STEP_DIV−1, advancing only when `en`=1.
- A step occurs when `en`=1 and `div_cnt`=STEP_DIV−1; `div_cnt` then returns to 0.
- With STEP_DIV=1, a step occurs on every enabled cycle.
- Position `pos` (clog2(N_LED) bits, range 0..N_LED−1) and direction bit `dir` (0=up) update on a step:
  - 00: pos = (pos==N_LED−1) ? 0 : pos+1; dir=0.
  - 01: pos = (pos==0) ? N_LED−1 : pos−1; dir=0.
  - 10: if dir=0, then pos<N_LED−1 → pos+1; at N_LED−1 → pos=N_LED−2, dir=1. If dir=1, then pos>0 → pos−1; at 0 → pos=1, dir=0.
  - 11: pos and dir unchanged. `step_pulse` still fires.
- `mode` is sampled only on step cycles. Mode changes between steps have no effect until the next step.
- Lit condition: led[pos] = (pwm_cnt < duty). All other bits are 0, except trail bits when the trail is compiled in.
- duty=0 gives `led` all zero. duty=2^PWM_BITS−1 gives on for (2^PWM_BITS−1) of every 2^PWM_BITS cycles.
- Comparisons are unsigned. `duty` is sampled every cycle, with no shadowing.

## Timing
- Reset values: `led`=0, `step_pulse`=0, pos=0, dir=0, div_cnt=0, pwm_cnt=0, trail history=0.
- `pos` updates on the clock edge that ends the step cycle. `step_pulse` is high for the one cycle during which the new `pos` is first visible.
- `led` is registered from the current pos/pwm_cnt/duty, so `led` lags `pos` by 1 cycle.
- Deasserting `en` freezes div_cnt, pos and dir; `pwm_cnt` and `led` PWM continue.
- Reasserting `en` resumes from the held div_cnt.
- `rst_n` low mid-step or mid-PWM period forces all state to reset values immediately (asynchronously). The first step after release occurs STEP_DIV enabled cycles later.

## Configuration
- Macro: `LED_PWM_CHASER_TRAIL_EN`.
- **Defined:**
  - Registers h1 and h2 hold the last two distinct previous positions. On a step that changes pos: h2←h1, h1←pos(old).
  - Hold mode and bounce turnarounds follow the same rule whenever pos changes.
  - led[h1] lit when pwm_cnt < (duty>>1); led[h2] lit when pwm_cnt < (duty>>2).
  - Priority: pos > h1 > h2 when indices coincide. After reset h1=h2=0=pos, so no trail is visible.
- **Undefined:** h1/h2 logic is absent and only led[pos] can be lit.

## Test plan
Bench parameters for all scenarios: N_LED=10, PWM_BITS=7, STEP_DIV=4.

1. Reset, en=1, mode=00, duty=127 → step_pulse every 4 cycles; pos sequence 1,2,…,9,0; led one-hot at pos, low only when pwm_cnt=127.
2. mode=10, same settings → pos 1..9,8,…,0,1; turnaround at 9→8 and 0→1 with no repeated position.
3. mode=01 from pos=0 → pos=9 on the next step; mode=11 → step_pulse continues while pos stays constant.
4. duty=32 → led[pos] high for exactly 32 of every 128 cycles; duty=0 → led=0 throughout.
5. en dropped for 10 cycles mid-count, then `rst_n` pulsed low mid-step → pos and div_cnt hold during en=0; reset zeroes everything asynchronously, and first step_pulse comes 4 cycles after release.
6. With `LED_PWM_CHASER_TRAIL_EN`, mode=00, duty=64, pos=5 → led[5] on 64/128 cycles, led[4] on 32/128, led[3] on 16/128, all others 0.
